// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    // Round-robin winner: first set bit of valid after ptr, wrapping modulo num (ptr itself is last).
    function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int num);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = (int'(ptr) + k) % num;
            if (!found && k <= num && valid[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: one-cycle tick every CLKS_PER_BIT clocks while enable is high.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic nReset,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ producers.
// Define UART_TX_SCHED_FRAME_CNT_EN to add the frameCount and dropWarn outputs.
//   state | meaning
//   IDLE  | no frame owned; waiting for a request with transmitter free
//   LOAD  | one cycle: byte handed to transmitter, requester acknowledged
//   SEND  | frame in flight; waiting for transmitter done
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                         clk,
    input  logic                         nReset,
    input  logic                         enable,
    input  logic [NUM_REQ-1:0]           reqValid,
    input  logic [8*NUM_REQ-1:0]         reqData,
    output logic [NUM_REQ-1:0]           reqReady,
    output logic                         txEn,
    output logic [UART_DATA_W-1:0]       txData,
    output logic                         txValid,
    input  logic                         txBusy,
    input  logic                         txDone,
    output logic [$clog2(NUM_REQ)-1:0]   grantId,
    output logic                         active
`ifdef UART_TX_SCHED_FRAME_CNT_EN
    ,
    output logic [15:0]                  frameCount,
    output logic                         dropWarn
`endif
);

    localparam int GW = $clog2(NUM_REQ);

    state_t                 state;
    state_t                 state_nxt;
    logic                   load_go;
    logic [GW-1:0]          ptr;
    logic [GW-1:0]          winner;
    logic [UART_DATA_W-1:0] win_data;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tick (
        .clk    (clk),
        .nReset (nReset),
        .enable (enable),
        .tick   (txEn)
    );

    always_comb begin
        winner   = GW'(rr_pick(8'(reqValid), 3'(ptr), NUM_REQ));
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == GW'(i)) begin
                win_data = reqData[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load_go   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (|reqValid) && !txBusy) begin
                    state_nxt = LOAD;
                    load_go   = 1'b1;
                end
            end
            LOAD: state_nxt = SEND;
            SEND: begin
                // Transmitter is entering STOP here, so it can take the next byte without a gap.
                if (txDone) begin
                    if (enable && (|reqValid)) begin
                        state_nxt = LOAD;
                        load_go   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            grantId <= '0;
            txData  <= '0;
            ptr     <= '0;
        end else begin
            state <= state_nxt;
            if (load_go) begin
                grantId <= winner;
                txData  <= win_data;
            end
            if (state == LOAD && (reqValid & reqReady) != '0) begin
                ptr <= grantId;
            end
        end
    end

    always_comb begin
        reqReady = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state == LOAD && grantId == GW'(i)) begin
                reqReady[i] = 1'b1;
            end
        end
    end

    assign txValid = (state == LOAD);
    assign active  = (state != IDLE);

`ifdef UART_TX_SCHED_FRAME_CNT_EN
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            frameCount <= '0;
            dropWarn   <= 1'b0;
        end else begin
            if (state == SEND && txDone) begin
                frameCount <= frameCount + 16'd1;
            end
            if (state == IDLE && txBusy) begin
                dropWarn <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a behavioural UART transmitter model.
module tb_uart_tx_sched;

    localparam int NR  = 4;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          nReset;
    logic          enable;
    logic [NR-1:0] reqValid;
    logic [8*NR-1:0] reqData;
    logic [NR-1:0] reqReady;
    logic          txEn;
    logic [7:0]    txData;
    logic          txValid;
    logic          txBusy;
    logic          txDone;
    logic [1:0]    grantId;
    logic          active;
`ifdef UART_TX_SCHED_FRAME_CNT_EN
    logic [15:0]   frameCount;
    logic          dropWarn;
`endif

    uart_tx_sched #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .enable   (enable),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqReady (reqReady),
        .txEn     (txEn),
        .txData   (txData),
        .txValid  (txValid),
        .txBusy   (txBusy),
        .txDone   (txDone),
        .grantId  (grantId),
        .active   (active)
`ifdef UART_TX_SCHED_FRAME_CNT_EN
        ,
        .frameCount (frameCount),
        .dropWarn   (dropWarn)
`endif
    );

    always #5 clk = ~clk;

    // Transmitter model: pos 0 idle, 1 start, 2..9 data, 10 stop; done pulses on the tick entering stop.
    logic [3:0] pos;
    logic       loaded;
    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            pos    <= '0;
            loaded <= 1'b0;
        end else begin
            if (txEn) begin
                if (pos == 4'd0) begin
                    if (loaded) begin
                        pos    <= 4'd1;
                        loaded <= 1'b0;
                    end
                end else if (pos == 4'd10) begin
                    if (loaded) begin
                        pos    <= 4'd1;
                        loaded <= 1'b0;
                    end else begin
                        pos <= 4'd0;
                    end
                end else begin
                    pos <= pos + 4'd1;
                end
            end
            if (txValid) loaded <= 1'b1;
        end
    end
    assign txBusy = loaded || (pos != 4'd0);
    assign txDone = txEn && (pos == 4'd9);

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   load_cnt = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;
    logic b2b_chk = 1'b0;
    logic hold_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every LOAD cycle is matched against the head of the expected-grant queue.
    always @(negedge clk) begin
        exp_t e;
        if (!nReset) begin
            done_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (txValid) begin
                load_cnt++;
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("grant_id", 32'(grantId), 32'(e.id));
                    check("tx_data", 32'(txData), 32'(e.data));
                    check("req_ready", 32'(reqReady), 32'd1 << e.id);
                    if (b2b_chk) check("b2b_gap", 32'(prev_done), 32'd1);
                end
            end
            if (txDone && active) done_cnt++;
            prev_done = txDone;
        end
    end

    // Producers drop reqValid after their byte is accepted unless told to hold.
    initial begin
        logic [NR-1:0] acc;
        forever begin
            @(negedge clk);
            if (!hold_valid && nReset && (reqValid & reqReady) != '0) begin
                acc = reqValid & reqReady;
                @(posedge clk);
                #1;
                reqValid = reqValid & ~acc;
            end
        end
    end

    task automatic wait_loads(input int target, input int budget, input string name);
        int n = 0;
        while (load_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (load_cnt < target) check({"timeout_", name}, 32'(load_cnt), 32'(target));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((active || txBusy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (active || txBusy) check("timeout_idle", 32'(active), 32'd0);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!txDone && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({"done_", name}, 32'(txDone), 32'd1);
    endtask

    task automatic wait_pos(input logic [3:0] val, input int budget);
        int n = 0;
        while (pos != val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pos != val) check("timeout_pos", 32'(pos), 32'(val));
    endtask

    initial begin
        int   base;
        logic saw;
        nReset   = 1'b0;
        enable   = 1'b0;
        reqValid = '0;
        reqData  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_txEn", 32'(txEn), 32'd0);
        check("rst_txValid", 32'(txValid), 32'd0);
        check("rst_txData", 32'(txData), 32'd0);
        check("rst_reqReady", 32'(reqReady), 32'd0);
        check("rst_grantId", 32'(grantId), 32'd0);
        check("rst_active", 32'(active), 32'd0);

        // Tick cadence: high on every 4th cycle counting the release cycle as cycle 1
        enable = 1'b1;
        nReset = 1'b1;
        #1;
        for (int n = 0; n < 12; n++) begin
            check($sformatf("tick_%0d", n), 32'(txEn), 32'((n % 4) == 3));
            @(negedge clk);
        end

        // Single requester
        wait_idle(100);
        exp_q.push_back('{id: 2'd0, data: 8'hA0});
        reqData[7:0] = 8'h55;
        exp_q[0].data = 8'h55;
        reqValid = 4'b0001;
        @(negedge clk);
        check("single_reqReady", 32'(reqReady), 32'h1);
        check("single_txValid", 32'(txValid), 32'd1);
        check("single_txData", 32'(txData), 32'h55);
        wait_done(200, "single");
        check("single_grant_hold", 32'(grantId), 32'd0);
        wait_idle(100);
        reqData[7:0] = 8'hA0;

        // Contention: all four held, pointer at 0 -> 1,2,3,0 back to back
        exp_q.push_back('{id: 2'd1, data: 8'hB1});
        exp_q.push_back('{id: 2'd2, data: 8'hC2});
        exp_q.push_back('{id: 2'd3, data: 8'hD3});
        exp_q.push_back('{id: 2'd0, data: 8'hA0});
        base = load_cnt;
        hold_valid = 1'b1;
        reqValid = 4'b1111;
        wait_loads(base + 1, 100, "cont_first");
        b2b_chk = 1'b1;
        wait_loads(base + 4, 1000, "cont_all");
        b2b_chk = 1'b0;
        reqValid = '0;
        hold_valid = 1'b0;
        wait_idle(300);

        // Stall mid-frame; requester 1 arrives during the stall and follows back to back
        exp_q.push_back('{id: 2'd2, data: 8'hC2});
        base = load_cnt;
        reqValid = 4'b0100;
        wait_loads(base + 1, 100, "stall_load");
        wait_pos(4'd4, 200);
        exp_q.push_back('{id: 2'd1, data: 8'hB1});
        enable = 1'b0;
        reqValid[1] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("stall_txEn", 32'(txEn), 32'd0);
            check("stall_txValid", 32'(txValid), 32'd0);
            check("stall_active", 32'(active), 32'd1);
        end
        enable = 1'b1;
        wait_done(200, "stall");
        wait_loads(base + 2, 50, "stall_next");
        wait_idle(300);

        // enable low in IDLE blocks new grants
        enable = 1'b0;
        exp_q.push_back('{id: 2'd0, data: 8'hA0});
        reqValid[0] = 1'b1;
        saw = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (active || txValid) saw = 1'b1;
        end
        check("idle_disabled_no_grant", 32'(saw), 32'd0);
        base = load_cnt;
        enable = 1'b1;
        wait_loads(base + 1, 50, "idle_enable");
        wait_idle(300);

        // Reset during data bit 3; pending requester 1 re-granted from pointer 0
        exp_q.push_back('{id: 2'd3, data: 8'hD3});
        base = load_cnt;
        reqValid[3] = 1'b1;
        wait_loads(base + 1, 100, "rst_load");
        reqValid[1] = 1'b1;
        wait_pos(4'd5, 200);
        nReset = 1'b0;
        #1;
        check("midrst_active", 32'(active), 32'd0);
        check("midrst_txValid", 32'(txValid), 32'd0);
        check("midrst_reqReady", 32'(reqReady), 32'd0);
        check("midrst_grantId", 32'(grantId), 32'd0);
        exp_q.push_back('{id: 2'd1, data: 8'hB1});
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        base = load_cnt;
        wait_loads(base + 1, 100, "rst_regrant");
        wait_idle(300);

`ifdef UART_TX_SCHED_FRAME_CNT_EN
        check("frame_count", 32'(frameCount), 32'(done_cnt));
`endif
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
